// File: rtl/divider_pkg.sv
// div_defs: definitions shared by the EX-stage divider, the HI/LO register
// and the hilo_en consumer.
//   DIV_IDLE/DIV_RUN/DIV_DONE : 2-bit FSM state encoding of the divider
//   DIV_STEPS                 : radix-2 iterations per operation
//   DIV_W                     : architectural register width
//   hilo_t / hilo_pack        : {HI, LO} = {remainder, quotient} packing order
package div_defs;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  localparam int DIV_STEPS = 32;
  localparam int DIV_W     = 32;

  // HI lives in the upper half of the 64-bit word, LO in the lower half.
  typedef struct packed {
    logic [DIV_W-1:0] hi;
    logic [DIV_W-1:0] lo;
  } hilo_t;

  // Build the {HI, LO} word from a remainder and a quotient.
  function automatic hilo_t hilo_pack(input logic [DIV_W-1:0] rem,
                                      input logic [DIV_W-1:0] quo);
    hilo_t w;
    w.hi = rem;
    w.lo = quo;
    return w;
  endfunction

endpackage

// File: rtl/divider_step.sv
// div_step: one combinational radix-2 restoring division iteration.
//   pr      : partial remainder {remainder bits, remaining dividend/quotient bits}
//   divisor : divisor magnitude
//   pr_next : partial remainder after shift / trial-subtract / select; the
//             freshly produced quotient bit is in pr_next[0]
module div_step
  import div_defs::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [2*WIDTH-1:0] pr,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] pr_next
);

  logic [2*WIDTH:0] shifted_s;
  logic [WIDTH:0]   trial_s;

  // Shift, trial-subtract the divisor from the upper half, keep or restore.
  always_comb begin
    shifted_s = {pr, 1'b0};
    // The bit shifted out of pr's MSB takes part in the compare: a remainder
    // of 2^31 or more doubles past 32 bits and must still subtract correctly.
    trial_s   = shifted_s[2*WIDTH:WIDTH] - {1'b0, divisor};
    if (trial_s[WIDTH] == 1'b0) begin
      pr_next = {trial_s[WIDTH-1:0], shifted_s[WIDTH-1:1], 1'b1};
    end else begin
      pr_next = shifted_s[2*WIDTH-1:0];
    end
  end

endmodule

// File: rtl/divider.sv
// divider: iterative radix-2 DIV/DIVU unit for the MIPS EX stage.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   start      : EX-stage instruction is DIV/DIVU
//   signed_div : signed operation, sampled with start
//   annul      : EX-stage flush; aborts a running operation
//   a, b       : dividend (rs), divisor (rt)
//   result     : {remainder, quotient}, held until the next completion
//   ready      : one-cycle pulse, result must be committed to HI/LO
//   stall      : freeze IF/ID/EX while the division is in progress
module divider
  import div_defs::*;
#(
  parameter int WIDTH = DIV_STEPS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

  logic [1:0]         state_r;
  logic [5:0]         cnt_r;
  logic [2*WIDTH-1:0] pr_r;
  logic [WIDTH-1:0]   dvs_r;
  logic               qneg_r;
  logic               rneg_r;
  logic [2*WIDTH-1:0] result_r;
  logic               ready_r;

  logic               accept_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [2*WIDTH-1:0] pr_next_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic               stall_s;

  // Two's-complement negation in WIDTH bits when en is set; wraps for -2^31.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] val,
                                              input logic en);
    logic [WIDTH-1:0] r;
    if (en) begin
      r = (~val) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = val;
    end
    return r;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr      (pr_r),
    .divisor (dvs_r),
    .pr_next (pr_next_s)
  );

  // Operand magnitudes and the accept condition seen in IDLE.
  always_comb begin
    accept_s = start & ~annul;
    a_neg_s  = signed_div & a[WIDTH-1];
    b_neg_s  = signed_div & b[WIDTH-1];
    a_mag_s  = neg_if(a, a_neg_s);
    b_mag_s  = neg_if(b, b_neg_s);
  end

  // Sign fix-up of the final step's output, registered on the last RUN edge.
  always_comb begin
    quo_fix_s = neg_if(pr_next_s[WIDTH-1:0], qneg_r);
    rem_fix_s = neg_if(pr_next_s[2*WIDTH-1:WIDTH], rneg_r);
  end

  // Pipeline freeze: same-cycle on an accepted start, held through RUN.
  always_comb begin
    case (state_r)
      DIV_IDLE: stall_s = accept_s;
      DIV_RUN:  stall_s = 1'b1;
      DIV_DONE: stall_s = 1'b0;
      default:  stall_s = 1'b0;
    endcase
  end

  // FSM, iteration registers and the registered result/ready outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= DIV_IDLE;
      cnt_r    <= 6'd0;
      pr_r     <= {(2*WIDTH){1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      qneg_r   <= 1'b0;
      rneg_r   <= 1'b0;
      result_r <= {(2*WIDTH){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          ready_r <= 1'b0;
          if (accept_s) begin
            cnt_r  <= 6'd0;
            pr_r   <= {{WIDTH{1'b0}}, a_mag_s};
            dvs_r  <= b_mag_s;
            qneg_r <= a_neg_s ^ b_neg_s;
            rneg_r <= a_neg_s;
            if (b == {WIDTH{1'b0}}) begin
              // Divide by zero: no iterations, dividend lands in HI.
              result_r <= {a, {WIDTH{1'b1}}};
              ready_r  <= 1'b1;
              state_r  <= DIV_DONE;
            end else begin
              state_r  <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          if (annul) begin
            // Squashed: result keeps the previous committed value.
            ready_r <= 1'b0;
            state_r <= DIV_IDLE;
          end else begin
            pr_r  <= pr_next_s;
            cnt_r <= cnt_r + 6'd1;
            if (cnt_r == LAST_CNT) begin
              result_r <= {rem_fix_s, quo_fix_s};
              ready_r  <= 1'b1;
              state_r  <= DIV_DONE;
            end
          end
        end
        DIV_DONE: begin
          ready_r <= 1'b0;
          state_r <= DIV_IDLE;
        end
        default: begin
          ready_r <= 1'b0;
          state_r <= DIV_IDLE;
        end
      endcase
    end
  end

  assign result = result_r;
  assign ready  = ready_r;
  assign stall  = stall_s;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider with a result scoreboard.
module tb_divider;
  import div_defs::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int errors;
  int checks;
  logic [63:0] sb[$];
  logic [63:0] prev;

  divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .a          (a),
    .b          (b),
    .result     (result),
    .ready      (ready),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operation starting next cycle, follow it to ready and score it.
  // With hold set, start stays high and the operands switch to na/nb after
  // cycle 0, modelling the next instruction waiting behind the stall.
  task automatic do_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sg, input logic [63:0] expv, input int exp_lat,
                        input logic hold, input logic [31:0] na, input logic [31:0] nb);
    int cyc;
    int stalls;
    logic [63:0] e;
    @(posedge clk); #1;
    start = 1'b1; a = av; b = bv; signed_div = sg;
    sb.push_back(expv);
    @(negedge clk);
    chk({tag, "_rdy_c0"}, {63'd0, ready}, 64'd0);
    stalls = stall ? 1 : 0;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      if (hold) begin
        a = na; b = nb;
      end else begin
        start = 1'b0;
      end
      cyc++;
      @(negedge clk);
      if (ready) break;
      if (stall) stalls++;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
    chk({tag, "_stall_done"}, {63'd0, stall}, 64'd0);
    chk({tag, "_result"}, result, e);
  endtask

  initial begin
    int rdy_seen;
    errors = 0; checks = 0;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_result", result, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_stall", {63'd0, stall}, 64'd0);

    do_div("u100_7", 32'd100, 32'd7, 1'b0, hilo_pack(32'd2, 32'd14), 33, 1'b0, 32'd0, 32'd0);
    do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, hilo_pack(32'hFFFF_FFFF, 32'hFFFF_FFFD), 33, 1'b0, 32'd0, 32'd0);
    do_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, hilo_pack(32'd1, 32'hFFFF_FFFD), 33, 1'b0, 32'd0, 32'd0);
    do_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, hilo_pack(32'd0, 32'h8000_0000), 33, 1'b0, 32'd0, 32'd0);
    do_div("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, hilo_pack(32'h8000_0000, 32'd0), 33, 1'b0, 32'd0, 32'd0);
    do_div("dbz", 32'h1234, 32'd0, 1'b0, hilo_pack(32'h1234, 32'hFFFF_FFFF), 1, 1'b0, 32'd0, 32'd0);

    // start together with annul in IDLE is not accepted
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; a = 32'd50; b = 32'd5; signed_div = 1'b0;
    @(negedge clk);
    chk("annul_idle_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    chk("annul_idle_next_stall", {63'd0, stall}, 64'd0);

    // annul in cycle 10 of a running operation
    prev = hilo_pack(32'h1234, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    start = 1'b1; a = 32'd1000; b = 32'd3; signed_div = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    chk("annul_c10_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    annul = 1'b0;
    @(negedge clk);
    chk("annul_next_stall", {63'd0, stall}, 64'd0);
    chk("annul_next_ready", {63'd0, ready}, 64'd0);
    chk("annul_result_held", result, prev);
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) rdy_seen++;
    end
    chk("annul_no_ready", 64'(rdy_seen), 64'd0);

    // reset in cycle 20 of a running operation
    @(posedge clk); #1;
    start = 1'b1; a = 32'd999; b = 32'd9; signed_div = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_run_result", result, 64'd0);
    chk("rst_run_ready", {63'd0, ready}, 64'd0);
    chk("rst_run_stall", {63'd0, stall}, 64'd0);
    rdy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) rdy_seen++;
    end
    chk("rst_no_ready", 64'(rdy_seen), 64'd0);

    // back-to-back DIVU with the second start held through the first RUN
    do_div("b2b_first", 32'hFFFF_FFFF, 32'd1, 1'b0, hilo_pack(32'd0, 32'hFFFF_FFFF), 33,
           1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_div("b2b_second", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, hilo_pack(32'd0, 32'd1), 33,
           1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("b2b_ready_pulse", {63'd0, ready}, 64'd0);
    chk("b2b_result_hold", result, 64'h0000_0000_0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Iterative 32-bit radix-2 divider for the MIPS EX stage, executing DIV and DIVU. It consumes the decoder's `div` and `hassign` flags together with the two register operands. It stalls the pipeline while it runs. When done it presents a 64-bit {remainder, quotient} word that the HI/LO write path commits (HI = remainder, LO = quotient).

## Interface
Parameters:
- `WIDTH`, 32: operand width; the result is `2*WIDTH` bits.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `start`  in  1  the EX-stage instruction is DIV/DIVU (the decoder's `div` flag).
- `signed_div`  in  1  signed operation (the decoder's `hassign`); sampled with `start`.
- `annul`  in  1  flush the EX stage (exception or branch squash); abort any operation.
- `a`  in  WIDTH  dividend (rs).
- `b`  in  WIDTH  divisor (rt).
- `result`  out  2*WIDTH  {remainder[63:32], quotient[31:0]}; holds its value until the next completion.
- `ready`  out  1  one-cycle pulse; `result` is valid and must be written to HI/LO.
- `stall`  out  1  freeze IF/ID/EX while the division is in progress.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - `start & ~annul` latches `a`, `b` and `signed_div`, clears the 6-bit counter, and moves to RUN.
  - If `signed_div` is set, both operands are converted to magnitudes, and two sign flags are recorded: `qneg = a[31]^b[31]` and `rneg = a[31]`.
- **RUN:** one restoring step per cycle on a 64-bit partial remainder.
  - Shift left by 1.
  - Trial-subtract `{|b|, 32'b0}` from the shifted partial remainder.
  - Keep the difference if it is non-negative and set the quotient LSB to 1; otherwise keep the shifted value and set the LSB to 0.
  - After 32 steps (counter reaches 31), the sign fix-up is registered into `result` and the state moves to DONE.
  - Quotient is negated if `qneg`; remainder is negated if `rneg`.
- **DONE:** `ready=1` for one cycle, then return to IDLE unconditionally.
- **Divide by zero** (`b==0` at start): skip RUN and go to DONE on the next edge with `result = {a, 32'hFFFF_FFFF}`.
- **Overflow case** 0x80000000 / 0xFFFFFFFF signed: result is q=0x80000000, r=0, produced naturally by the 32-bit wrap of the negation.
- `start` while in RUN or DONE is ignored; the pipeline is frozen, so the instruction is re-presented only after DONE.
- `annul` in RUN or DONE returns to IDLE on the next edge. In that case `ready` is not asserted and `result` is left unchanged. `annul` has priority over `start`.
- `rst`: state IDLE, counter 0, `result` 0, `ready` 0, `stall` 0.

## Timing
- Cycle 0: `start` is presented in IDLE, and `stall = start & ~annul` (combinational, same cycle).
- Cycles 1–32: RUN with `stall=1`.
- The edge ending cycle 32 writes `result`.
- Cycle 33: DONE, `ready=1`, `stall=0`; EX/MEM advances and captures `result`.
- Total latency: 33 stall cycles, with the result usable in cycle 33.
- Divide by zero: stall in cycle 0 only; `ready` in cycle 1.
- `stall` is a pure function of state, `start` and `annul`. `ready` and `result` are registered.
- A new `start` is accepted in the cycle after DONE at the earliest.
- Reset asserted mid-RUN takes effect on the next edge. The following cycle shows IDLE with all outputs 0.

## Structure
- Shared package `div_defs`:
  - Constants `DIV_IDLE`, `DIV_RUN` and `DIV_DONE` (2-bit state encoding).
  - `DIV_STEPS = 32`.
  - The {HI, LO} packing order, shared with the HI/LO register and the `hilo_en` consumer.
- One natural sub-module, `div_step`: combinational shift / trial-subtract / select for a single iteration. It is instantiated once and registered by the FSM, leaving room for a future radix-4 unrolled version.

## Test plan
- Unsigned 100 / 7: `ready` in cycle 33, `result = {32'd2, 32'd14}`, and `stall` is high for cycles 0–32 exactly.
- Signed -7 / 2 (0xFFFFFFF9 / 2): q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 / -2: q=0xFFFFFFFD, r=1.
- Signed 0x80000000 / 0xFFFFFFFF: q=0x80000000, r=0. The same operands unsigned: q=0, r=0x80000000.
- Divide by zero, a=0x1234, b=0: `ready` in cycle 1, `result = {32'h1234, 32'hFFFFFFFF}`.
- Abort cases:
  - `annul` in cycle 10: IDLE next cycle, no `ready` pulse, `result` still holds the previous value.
  - `rst` in cycle 20: all outputs 0 next cycle.
- Back-to-back DIVU 0xFFFFFFFF / 1 then 0xFFFFFFFF / 0xFFFFFFFF:
  - Second `start` held through the first operation's RUN has no effect.
  - First result is {0, 0xFFFFFFFF}; second, started after DONE, is {0, 1}.
